zass_mat_loader: RTL and testbench
==================================

# zass_mat_loader

Front-end loader for the Gaussian-elimination stage of the ROLLO decoder. It streams the basis vectors of two subspaces U and V and builds the Zassenhaus matrix row by row in the shared matrix memory: {u,u} rows first, then {v,0} rows, then zero padding. It then launches `gs_elim_ctrl` with `start`/`mat_sel`/`is_last` and waits for its `done`. It sits directly upstream of `gs_elim_ctrl` and owns the memory write port while loading.

## Interface
- `k`, default 6: rows of the full matrix (`mat_sel`=0).
- `k1`, default 5: rows of the reduced matrix (`mat_sel`=1); k1 < k.
- `l`, default 4: row width in bits; must be even. ls2 = l/2 is the width of one basis vector.
- `clk` input, 1 bit: single clock, rising edge.
- `rst_b` input, 1 bit: asynchronous, active-low reset.
- `load_start` input, 1 bit: one-cycle request to build a matrix. Sampled only in IDLE.
- `n_u` input, CLOG2(k+1) bits: number of U vectors. Sampled with `load_start`.
- `n_v` input, CLOG2(k+1) bits: number of V vectors. Sampled with `load_start`.
- `mat_sel_in` input, 1 bit: sampled with `load_start`.
- `is_last_in` input, 1 bit: sampled with `load_start`.
- `vec_in` input, ls2 bits: basis vector data.
- `vec_valid` input, 1 bit: `vec_in` is valid.
- `vec_ready` output, 1 bit: loader accepts a vector this cycle.
- `mem_addr` output, CLOG2(k) bits: write row address.
- `mem_dout` output, l bits: write data.
- `mem_we` output, 1 bit: write strobe.
- `ge_start` output, 1 bit: one-cycle start pulse to `gs_elim_ctrl`.
- `ge_mat_sel` output, 1 bit: registered `mat_sel_in`, held stable from `ge_start` until `done`.
- `ge_is_last` output, 1 bit: registered `is_last_in`, held stable from `ge_start` until `done`.
- `ge_done` input, 1 bit: done from `gs_elim_ctrl`.
- `busy` output, 1 bit: high in every state except IDLE.
- `done` output, 1 bit: one-cycle pulse when elimination completes.
- `err` output, 1 bit: one-cycle pulse when a request is rejected.

## Operation
- R = `mat_sel_in` ? k1 : k, latched at `load_start`. A row counter `row` (0..R-1) drives `mem_addr`.
- States and transitions:
  - IDLE: on `load_start`:
    - `n_u`+`n_v` > R: pulse `err`, stay in IDLE, no writes.
    - otherwise latch all inputs, set `row`=0, go to LOAD_U. If `n_u`=0 go to LOAD_V; if both are 0 go to PAD.
  - LOAD_U: `vec_ready`=1. Each handshake (`vec_valid`&`vec_ready`) writes {vec_in,vec_in} to `row` and increments `row`. After the `n_u`-th handshake go to LOAD_V, or to PAD if `n_v`=0.
  - LOAD_V: same as LOAD_U, but writes {vec_in, ls2'b0}. After the `n_v`-th handshake go to PAD.
  - PAD: writes zero rows, one per cycle, for `row` = `n_u`+`n_v`..R-1, then go to KICK. If `n_u`+`n_v`=R, pass straight to KICK with no writes.
  - KICK: pulse `ge_start` for one cycle, then go to WAIT.
  - WAIT: `mem_we`=0 throughout. On `ge_done`, pulse `done`, go to IDLE.
- `vec_valid` is ignored outside LOAD_U/LOAD_V. Stalls of `vec_valid` insert idle cycles with `mem_we`=0.
- `load_start` while `busy` is ignored; no `err` is raised.
- `ge_done` outside WAIT is ignored.

## Timing
- All outputs are registered. Reset values: `vec_ready`=0, `mem_we`=0, `mem_addr`=0, `mem_dout`=0, `ge_start`=0, `ge_mat_sel`=0, `ge_is_last`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- `vec_ready` rises the cycle after `load_start` is accepted. It falls in the cycle after the final handshake, so at most one extra vector is never accepted.
- A handshake at cycle t produces `mem_we`=1 with the matching `mem_addr`/`mem_dout` at cycle t+1.
- The last write (data or pad) is at cycle p. `ge_start` is high at cycle p+1, or p+2 if the final data row needed the PAD state pass-through.
- `ge_done` at cycle t gives `done`=1 and `busy`=0 at cycle t+1.
- The earliest new `load_start` is accepted at cycle t+1.
- Minimum latency from `load_start` to `ge_start` (streaming, with padding) is R+2 cycles.
- `rst_b` low at any point: all outputs return to reset values immediately. Partially written memory is left as is; no `ge_start` or `done` is issued.

## Configuration
- `ZASS_ZERO_PAD_EN` defined: the PAD state writes zero rows as described above.
- Undefined: PAD is skipped and the FSM goes directly to KICK after the last vector. The memory must already hold zeros in the unused rows. `ge_start` then follows the last data write by exactly one cycle.

## Test plan
- k=6, l=4, `mat_sel_in`=0, n_u=2 (u=2'b01, 2'b10), n_v=2 (v=2'b11, 2'b01), continuous valid:
  - writes rows 0..5 = 4'b0101, 4'b1010, 4'b1100, 4'b0100, 0, 0 on consecutive cycles;
  - `ge_start` pulses once after row 5;
  - `ge_done` then gives a single `done` pulse.
- `mat_sel_in`=1, n_u=3, n_v=2:
  - R=5, exactly 5 writes, no write to row 5, `ge_mat_sel`=1 held until `done`.
- `vec_valid` toggled 1,0,0,1,… with n_u=1, n_v=1:
  - writes occur only on handshake+1 cycles, `mem_we` is 0 in stall cycles, addresses are 0 then 1.
- n_u=4, n_v=3, k=6:
  - `err` pulses for one cycle, `busy` stays 0, no `mem_we` and no `ge_start`.
- `rst_b` asserted in the middle of LOAD_V, then released, then a new request with n_u=0, n_v=6:
  - all outputs are at reset values during reset;
  - the new run writes {v,00} to rows 0..5 and issues `ge_start`.
- `ZASS_ZERO_PAD_EN` undefined, n_u=1, n_v=1:
  - only rows 0..1 are written, `ge_start` follows the row-1 write by one cycle.

Source files
------------

// File: rtl/zass_mat_loader_if.sv
// zass_mat_loader_if: vector stream, matrix-memory write port and gs_elim_ctrl handshake of the loader.
// master is the loader side; slave is the source/memory/eliminator side.
interface zass_mat_loader_if #(
    parameter int k = 6,
    parameter int l = 4
);
    logic [l/2-1:0]       vec_in;
    logic                 vec_valid;
    logic                 vec_ready;
    logic [$clog2(k)-1:0] mem_addr;
    logic [l-1:0]         mem_dout;
    logic                 mem_we;
    logic                 ge_start;
    logic                 ge_mat_sel;
    logic                 ge_is_last;
    logic                 ge_done;
    modport master (
        input  vec_in, vec_valid, ge_done,
        output vec_ready, mem_addr, mem_dout, mem_we, ge_start, ge_mat_sel, ge_is_last
    );
    modport slave (
        output vec_in, vec_valid, ge_done,
        input  vec_ready, mem_addr, mem_dout, mem_we, ge_start, ge_mat_sel, ge_is_last
    );
endinterface

// File: rtl/zass_mat_loader.sv
// zass_mat_loader: builds the Zassenhaus matrix ({u,u} rows, {v,0} rows, zero pad) and launches gs_elim_ctrl.
// Define ZASS_ZERO_PAD_EN to have the loader write the zero padding rows itself.
module zass_mat_loader #(
    parameter int k  = 6,
    parameter int k1 = 5,
    parameter int l  = 4
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   load_start,
    input  logic [$clog2(k+1)-1:0] n_u,
    input  logic [$clog2(k+1)-1:0] n_v,
    input  logic                   mat_sel_in,
    input  logic                   is_last_in,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    zass_mat_loader_if.master      bus
);
    localparam int cw  = $clog2(k+1);
    localparam int aw  = $clog2(k);
    localparam int ls2 = l/2;
    localparam logic [cw:0] rk  = (cw+1)'(k);
    localparam logic [cw:0] rk1 = (cw+1)'(k1);

    typedef enum logic [2:0] {IDLE, LOAD_U, LOAD_V, PAD, KICK, WAIT} state_t;

`ifdef ZASS_ZERO_PAD_EN
    localparam state_t after_load = PAD;
`else
    localparam state_t after_load = KICK;
`endif

    state_t            state_q, state_d;
    logic [cw:0]       row_q, row_d, nu_q, nu_d, tot_q, tot_d, r_q, r_d;
    logic [cw:0]       sum_in, r_in, row_nx;
    logic              vec_ready_q, vec_ready_d, mem_we_q, mem_we_d;
    logic [aw-1:0]     mem_addr_q, mem_addr_d;
    logic [l-1:0]      mem_dout_q, mem_dout_d;
    logic              ge_start_q, ge_start_d, mat_sel_q, mat_sel_d, is_last_q, is_last_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              hs;
    logic [ls2-1:0]    lo_half;

    assign sum_in = {1'b0, n_u} + {1'b0, n_v};
    assign r_in   = mat_sel_in ? rk1 : rk;

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        nu_d       = nu_q;
        tot_d      = tot_q;
        r_d        = r_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_dout_d = mem_dout_q;
        ge_start_d = 1'b0;
        mat_sel_d  = mat_sel_q;
        is_last_d  = is_last_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        hs         = vec_ready_q & bus.vec_valid;
        row_nx     = row_q + 1'b1;
        lo_half    = state_q == LOAD_U ? bus.vec_in : '0;
        case (state_q)
            IDLE: if (load_start) begin
                if (sum_in > r_in) begin
                    err_d = 1'b1;
                end else begin
                    nu_d      = {1'b0, n_u};
                    tot_d     = sum_in;
                    r_d       = r_in;
                    row_d     = '0;
                    mat_sel_d = mat_sel_in;
                    is_last_d = is_last_in;
                    state_d   = n_u != '0 ? LOAD_U : n_v != '0 ? LOAD_V : after_load;
                end
            end
            LOAD_U, LOAD_V: if (hs) begin
                mem_we_d   = 1'b1;
                mem_addr_d = row_q[aw-1:0];
                mem_dout_d = {bus.vec_in, lo_half};
                row_d      = row_nx;
                if (state_q == LOAD_U && row_nx == nu_q)
                    state_d = tot_q == nu_q ? after_load : LOAD_V;
                if (state_q == LOAD_V && row_nx == tot_q)
                    state_d = after_load;
            end
            // A full matrix falls through PAD without writing, costing one cycle.
            PAD: if (row_q < r_q) begin
                mem_we_d   = 1'b1;
                mem_addr_d = row_q[aw-1:0];
                mem_dout_d = '0;
                row_d      = row_nx;
                state_d    = row_nx == r_q ? KICK : PAD;
            end else begin
                state_d = KICK;
            end
            KICK: begin
                ge_start_d = 1'b1;
                state_d    = WAIT;
            end
            WAIT: if (bus.ge_done) begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        vec_ready_d = state_d == LOAD_U || state_d == LOAD_V;
        busy_d      = state_d != IDLE;
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= IDLE;
            row_q       <= '0;
            nu_q        <= '0;
            tot_q       <= '0;
            r_q         <= '0;
            vec_ready_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_dout_q  <= '0;
            ge_start_q  <= 1'b0;
            mat_sel_q   <= 1'b0;
            is_last_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            nu_q        <= nu_d;
            tot_q       <= tot_d;
            r_q         <= r_d;
            vec_ready_q <= vec_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_dout_q  <= mem_dout_d;
            ge_start_q  <= ge_start_d;
            mat_sel_q   <= mat_sel_d;
            is_last_q   <= is_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.vec_ready  = vec_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_dout   = mem_dout_q;
    assign bus.ge_start   = ge_start_q;
    assign bus.ge_mat_sel = mat_sel_q;
    assign bus.ge_is_last = is_last_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
endmodule

// File: tb/tb_zass_mat_loader.sv
// tb_zass_mat_loader: directed bench for zass_mat_loader (k=6, k1=5, l=4), acting as vector source,
// matrix memory and gs_elim_ctrl; expectations follow ZASS_ZERO_PAD_EN when it is defined.
module tb_zass_mat_loader;
    localparam int k = 6, k1 = 5, l = 4;
`ifdef ZASS_ZERO_PAD_EN
    localparam bit pad_en = 1'b1;
`else
    localparam bit pad_en = 1'b0;
`endif

    logic       clk = 1'b0, rst_b = 1'b0;
    logic       load_start = 1'b0, mat_sel_in = 1'b0, is_last_in = 1'b0;
    logic [2:0] n_u = '0, n_v = '0;
    logic       busy, done, err;
    int         checks = 0, failures = 0, cyc = 0;
    int         wr_cyc[$], wr_adr[$], wr_dat[$], gs_cyc[$], dn_cyc[$], er_cyc[$];
    int         busy_n = 0, dn_busy = 0, ms_chg = 0, t0 = 0, gd = 0, dummy = 0;
    logic       ms_at_gs = 1'b0, dn_ms = 1'b0;
    bit         in_ge = 1'b0;
    logic [14:0] outs;

    zass_mat_loader_if #(.k(k), .l(l)) bus ();

    zass_mat_loader #(.k(k), .k1(k1), .l(l)) dut (
        .clk(clk), .rst_b(rst_b), .load_start(load_start), .n_u(n_u), .n_v(n_v),
        .mat_sel_in(mat_sel_in), .is_last_in(is_last_in), .busy(busy), .done(done),
        .err(err), .bus(bus)
    );

    assign outs = {bus.vec_ready, bus.mem_we, bus.mem_addr, bus.mem_dout, bus.ge_start,
                   bus.ge_mat_sel, bus.ge_is_last, busy, done, err};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            wr_cyc.push_back(cyc);
            wr_adr.push_back(int'(bus.mem_addr));
            wr_dat.push_back(int'(bus.mem_dout));
        end
        if (bus.ge_start) begin
            gs_cyc.push_back(cyc);
            ms_at_gs = bus.ge_mat_sel;
            in_ge = 1'b1;
        end else if (in_ge && bus.ge_mat_sel !== ms_at_gs) begin
            ms_chg++;
        end
        if (done) begin
            dn_cyc.push_back(cyc);
            dn_busy += int'(busy);
            dn_ms = bus.ge_mat_sel;
            in_ge = 1'b0;
        end
        if (err) er_cyc.push_back(cyc);
        if (busy) busy_n++;
    end

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return i < q.size() ? q[i] : -1;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clr();
        wr_cyc.delete(); wr_adr.delete(); wr_dat.delete();
        gs_cyc.delete(); dn_cyc.delete(); er_cyc.delete();
        busy_n = 0; dn_busy = 0; ms_chg = 0; in_ge = 1'b0;
    endtask

    task automatic req(input int nu, input int nv, input bit ms, input bit il, output int ts);
        n_u = 3'(nu); n_v = 3'(nv); mat_sel_in = ms; is_last_in = il;
        load_start = 1'b1;
        ts = cyc;
        tick(1);
        load_start = 1'b0;
    endtask

    // vv holds vector 0 in its top two bits; pat holds the valid pattern, first step in bit plen-1.
    task automatic feed(input logic [11:0] vv, input int n, input logic [3:0] pat, input int plen,
                        input bit extra);
        int i = 0, s = 0;
        logic hs;
        while (i < n && s < 200) begin
            bus.vec_in = vv[11-2*i -: 2];
            bus.vec_valid = pat[plen-1-(s % plen)];
            hs = bus.vec_valid & bus.vec_ready;
            tick(1);
            s++;
            if (hs) i++;
        end
        chk("feed_accepted", i, n);
        bus.vec_in = 2'b11;
        bus.vec_valid = extra;
        tick(1);
        bus.vec_valid = 1'b0;
    endtask

    task automatic wait_gs();
        int b = 0;
        while (gs_cyc.size() == 0 && b < 100) begin
            tick(1);
            b++;
        end
        chk("ge_start_seen", int'(gs_cyc.size() > 0), 1);
    endtask

    task automatic finish_run(output int gdc);
        wait_gs();
        tick(2);
        bus.ge_done = 1'b1;
        gdc = cyc;
        tick(1);
        bus.ge_done = 1'b0;
        tick(2);
    endtask

    task automatic chk_run(input string tag, input int n, input logic [23:0] dat, input int c0,
                           input int gs_exp, input int gdc);
        chk({tag, "_nwr"}, wr_adr.size(), n);
        for (int i = 0; i < n; i++) begin
            chk({tag, "_adr"}, qget(wr_adr, i), i);
            chk({tag, "_dat"}, qget(wr_dat, i), int'(dat[23-4*i -: 4]));
            if (c0 >= 0) chk({tag, "_wcyc"}, qget(wr_cyc, i), c0 + i);
        end
        chk({tag, "_ngs"}, gs_cyc.size(), 1);
        chk({tag, "_gs_cyc"}, qget(gs_cyc, 0), gs_exp);
        chk({tag, "_ndone"}, dn_cyc.size(), 1);
        chk({tag, "_done_cyc"}, qget(dn_cyc, 0), gdc + 1);
        chk({tag, "_busy_at_done"}, dn_busy, 0);
        chk({tag, "_nerr"}, er_cyc.size(), 0);
    endtask

    initial begin
        bus.vec_in = '0;
        bus.vec_valid = 1'b0;
        bus.ge_done = 1'b0;
        tick(2);
        chk("reset_outs", int'(outs), 0);
        rst_b = 1'b1;
        tick(1);

        // Streaming {u,u}/{v,0} rows, plus an ignored request while waiting on elimination.
        clr();
        req(2, 2, 1'b0, 1'b0, t0);
        feed({2'b01, 2'b10, 2'b11, 2'b01, 4'b0}, 4, 4'b1111, 4, 1'b1);
        wait_gs();
        req(4, 3, 1'b0, 1'b0, dummy);
        finish_run(gd);
        chk_run("s1", pad_en ? 6 : 4, 24'h5AC400, t0 + 2, t0 + (pad_en ? 8 : 6), gd);

        // Reduced matrix filled exactly: no row 5, mat_sel held through done.
        clr();
        req(3, 2, 1'b1, 1'b0, t0);
        feed({2'b01, 2'b10, 2'b11, 2'b10, 2'b11, 2'b0}, 5, 4'b1111, 4, 1'b1);
        finish_run(gd);
        chk_run("s2", 5, 24'h5AF8C0, t0 + 2, t0 + (pad_en ? 8 : 7), gd);
        chk("s2_ms_held", ms_chg, 0);
        chk("s2_ms_at_done", int'(dn_ms), 1);

        // Stalled valid; a stray ge_done in IDLE must be ignored.
        clr();
        bus.ge_done = 1'b1;
        tick(1);
        bus.ge_done = 1'b0;
        req(1, 1, 1'b0, 1'b1, t0);
        feed({2'b10, 2'b01, 8'b0}, 2, 4'b1001, 4, 1'b1);
        finish_run(gd);
        chk_run("s3", pad_en ? 6 : 2, 24'hA40000, -1, t0 + (pad_en ? 10 : 6), gd);
        chk("s3_wr0_cyc", qget(wr_cyc, 0), t0 + 2);
        chk("s3_wr1_cyc", qget(wr_cyc, 1), t0 + 5);

        // Oversized request is rejected.
        clr();
        req(4, 3, 1'b0, 1'b0, t0);
        tick(4);
        chk("s4_nerr", er_cyc.size(), 1);
        chk("s4_err_cyc", qget(er_cyc, 0), t0 + 1);
        chk("s4_busy", busy_n, 0);
        chk("s4_nwr", wr_adr.size(), 0);
        chk("s4_ngs", gs_cyc.size(), 0);

        // Reset in the middle of LOAD_V, then a V-only request.
        req(1, 2, 1'b1, 1'b1, t0);
        feed({2'b10, 2'b01, 8'b0}, 2, 4'b1111, 4, 1'b0);
        chk("s5_pre_rst_ms", int'(bus.ge_mat_sel), 1);
        clr();
        rst_b = 1'b0;
        #1;
        chk("s5_rst_outs", int'(outs), 0);
        tick(2);
        chk("s5_rst_outs_held", int'(outs), 0);
        rst_b = 1'b1;
        tick(1);
        req(0, 6, 1'b0, 1'b0, t0);
        feed({2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b11}, 6, 4'b1111, 4, 1'b1);
        finish_run(gd);
        chk_run("s5", 6, 24'h48C48C, t0 + 2, t0 + (pad_en ? 9 : 8), gd);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
